fetch_redirect_controller: RTL

Sequences the fetch stage's control inputs: it arbitrates redirect requests from execute (branch mispredict) and decode (early jump), and holds fetch in flush for the synchronous-IMem refill window. It also forwards back-end hazard stalls. It drives the fetch stage's `stall`, `flush` and `irregPc` and sits inside the pipeline controller, between the back-end hazard/branch-resolve logic and the fetch stage. All outputs are registered.

---
 rtl/fetch_redirect_controller.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fetch_redirect_controller.sv
// fetch_redirect_controller: arbitrates execute/decode redirects, holds
// fetch in flush across the IMem refill window and forwards hazard stalls.
module fetch_redirect_controller #(
    parameter int ADDR_WIDTH    = 32,
    parameter int REFILL_CYCLES = 1,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exRedirectValid,
    input  logic [ADDR_WIDTH-1:0] exRedirectPc,
    input  logic                  idRedirectValid,
    input  logic [ADDR_WIDTH-1:0] idRedirectPc,
    input  logic                  hazardStall,
    output logic                  fetchStall,
    output logic                  fetchFlush,
    output logic                  irregPcValid,
    output logic [ADDR_WIDTH-1:0] irregPc,
    output logic                  redirectBusy,
    output logic [CNT_WIDTH-1:0]  mispredictCount
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_REFILL   = 2'd2
    } state_e;

    localparam logic [2:0] REFILL_INIT = 3'(REFILL_CYCLES);

    state_e                state_q, state_d;
    logic [2:0]            refill_cnt_q, refill_cnt_d;
    logic [ADDR_WIDTH-1:0] target_q, target_d;
    logic [CNT_WIDTH-1:0]  mp_cnt_q, mp_cnt_d;

    logic                  stall_q, stall_d;
    logic                  flush_q, flush_d;
    logic                  irreg_valid_q, irreg_valid_d;
    logic [ADDR_WIDTH-1:0] irreg_pc_q, irreg_pc_d;
    logic                  busy_q, busy_d;

    // Next state: execute wins everywhere, decode only from an idle fetch.
    always_comb begin
        state_d      = state_q;
        refill_cnt_d = refill_cnt_q;
        target_d     = target_q;
        mp_cnt_d     = mp_cnt_q;
        if (exRedirectValid) begin
            state_d  = S_REDIRECT;
            target_d = exRedirectPc;
            if (mp_cnt_q != '1) begin
                mp_cnt_d = mp_cnt_q + CNT_WIDTH'(1);
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (idRedirectValid) begin
                        state_d  = S_REDIRECT;
                        target_d = idRedirectPc;
                    end
                end
                S_REDIRECT: begin
                    if (REFILL_INIT == 3'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d      = S_REFILL;
                        refill_cnt_d = REFILL_INIT;
                    end
                end
                S_REFILL: begin
                    // A held back-end freezes the refill window.
                    if (!hazardStall) begin
                        if (refill_cnt_q <= 3'd1) begin
                            state_d      = S_IDLE;
                            refill_cnt_d = 3'd0;
                        end else begin
                            refill_cnt_d = refill_cnt_q - 3'd1;
                        end
                    end
                end
                default: begin
                    state_d      = S_IDLE;
                    refill_cnt_d = 3'd0;
                end
            endcase
        end
    end

    // Outputs decoded from the next state so they register with it.
    always_comb begin
        stall_d       = 1'b0;
        flush_d       = 1'b0;
        irreg_valid_d = 1'b0;
        irreg_pc_d    = '0;
        busy_d        = (state_d != S_IDLE);
        unique case (state_d)
            S_IDLE: begin
                stall_d = hazardStall;
            end
            S_REDIRECT: begin
                irreg_valid_d = 1'b1;
                irreg_pc_d    = target_d;
                flush_d       = 1'b1;
            end
            S_REFILL: begin
                flush_d = 1'b1;
                stall_d = hazardStall;
            end
            default: begin
                stall_d = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            refill_cnt_q  <= 3'd0;
            target_q      <= '0;
            mp_cnt_q      <= '0;
            stall_q       <= 1'b0;
            flush_q       <= 1'b0;
            irreg_valid_q <= 1'b0;
            irreg_pc_q    <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            refill_cnt_q  <= refill_cnt_d;
            target_q      <= target_d;
            mp_cnt_q      <= mp_cnt_d;
            stall_q       <= stall_d;
            flush_q       <= flush_d;
            irreg_valid_q <= irreg_valid_d;
            irreg_pc_q    <= irreg_pc_d;
            busy_q        <= busy_d;
        end
    end

    assign fetchStall      = stall_q;
    assign fetchFlush      = flush_q;
    assign irregPcValid    = irreg_valid_q;
    assign irregPc         = irreg_pc_q;
    assign redirectBusy    = busy_q;
    assign mispredictCount = mp_cnt_q;

endmodule
